// File: rtl/stepper_unipolar_ctrl.sv
// stepper_unipolar_ctrl: sequencer for a 4-coil unipolar stepper (28BYJ-48 class).
// Provides wave, double and half-step sequencing, a programmable step period,
// and counted or continuous moves.
//
// Handshake: start is accepted only in IDLE. The accepting cycle latches mode,
// direcc, period, steps and continuous. busy is high for the whole move. stop
// is honoured only in RUN. done pulses for exactly one cycle when a move ends,
// whether it completes, is stopped, or is a zero-length request. The FSM state
// is visible on busy, which is high exactly when the controller is in RUN.
module stepper_unipolar_ctrl #(
  parameter int DIV_W      = 24,
  parameter int CNT_W      = 16,
  parameter int PERIOD_MIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             direcc,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] steps,
  input  logic             continuous,
  input  logic             start,
  input  logic             stop,
  input  logic             hold_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic [3:0]       bobinasMotor,
  output logic             ledDirecc
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam logic [DIV_W-1:0] PERIOD_MIN_V = DIV_W'(PERIOD_MIN);

  logic             state, state_next;
  logic [2:0]       idx, idx_next;
  logic [DIV_W-1:0] div_cnt, div_next;
  logic [DIV_W-1:0] period_l, period_next;
  logic [CNT_W-1:0] left_next;
  logic             cont_l, cont_next;
  logic             half_l, half_next;
  logic             dir_l, dir_next;
  logic             led_next;
  logic             done_next;
  logic [3:0]       coil_next;
  logic             start_ok;
  logic             step_tick;
  logic [2:0]       stride;
  logic [2:0]       idx_aligned;

  // Coil pattern for each sequence index; even entries are single-coil,
  // odd entries energise two adjacent coils.
  function automatic logic [3:0] seq_pattern(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Next-state logic: move acceptance, divider, step advance and move termination.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    div_next    = div_cnt;
    period_next = period_l;
    left_next   = steps_left;
    cont_next   = cont_l;
    half_next   = half_l;
    dir_next    = dir_l;
    led_next    = ledDirecc;
    done_next   = 1'b0;

    start_ok  = start && (continuous || (steps != '0));
    step_tick = (div_cnt == (period_l - DIV_W'(1)));
    stride    = half_l ? 3'd1 : 3'd2;

    // Wave lives on even indices, double on odd ones, half keeps the current index.
    case (mode)
      2'b00:   idx_aligned = {idx[2:1], 1'b0};
      2'b10:   idx_aligned = idx;
      default: idx_aligned = {idx[2:1], 1'b1};
    endcase

    case (state)
      STATE_IDLE: begin
        if (start_ok) begin
          state_next  = STATE_RUN;
          idx_next    = idx_aligned;
          div_next    = '0;
          period_next = (period < PERIOD_MIN_V) ? PERIOD_MIN_V : period;
          left_next   = continuous ? '0 : steps;
          cont_next   = continuous;
          half_next   = (mode == 2'b10);
          dir_next    = direcc;
          led_next    = direcc;
        end else if (start) begin
          // Zero-length counted move: acknowledge without touching the coils.
          done_next = 1'b1;
        end
      end
      default: begin
        if (step_tick) begin
          div_next = '0;
          idx_next = dir_l ? (idx + stride) : (idx - stride);
          if (!cont_l) begin
            left_next = steps_left - CNT_W'(1);
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
        // A final tick and stop in the same cycle end the move only once.
        if ((step_tick && !cont_l && (steps_left == CNT_W'(1))) || stop) begin
          state_next = STATE_IDLE;
          div_next   = '0;
          done_next  = 1'b1;
        end
      end
    endcase

    // The pattern is always driven while a move is in progress or starting,
    // including the edge that ends it; afterwards hold_en decides.
    if ((state == STATE_RUN) || (state_next == STATE_RUN) || hold_en) begin
      coil_next = seq_pattern(idx_next);
    end else begin
      coil_next = 4'b0000;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= STATE_IDLE;
      idx          <= 3'd0;
      div_cnt      <= '0;
      period_l     <= PERIOD_MIN_V;
      steps_left   <= '0;
      cont_l       <= 1'b0;
      half_l       <= 1'b0;
      dir_l        <= 1'b0;
      ledDirecc    <= 1'b0;
      done         <= 1'b0;
      bobinasMotor <= 4'b0000;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      div_cnt      <= div_next;
      period_l     <= period_next;
      steps_left   <= left_next;
      cont_l       <= cont_next;
      half_l       <= half_next;
      dir_l        <= dir_next;
      ledDirecc    <= led_next;
      done         <= done_next;
      bobinasMotor <= coil_next;
    end
  end

  assign busy = (state == STATE_RUN);

endmodule

// File: tb/tb_stepper_unipolar_ctrl.sv
// Bench for stepper_unipolar_ctrl: directed moves checked every cycle against
// a position-from-elapsed-time model, plus literal coil sequences and counts.
module tb_stepper_unipolar_ctrl;

  localparam int DIV_W = 24;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       mode;
  logic             direcc;
  logic [DIV_W-1:0] period;
  logic [CNT_W-1:0] steps;
  logic             continuous;
  logic             start;
  logic             stop;
  logic             hold_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;
  logic [3:0]       bobinasMotor;
  logic             ledDirecc;

  stepper_unipolar_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .PERIOD_MIN(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .direcc(direcc), .period(period),
    .steps(steps), .continuous(continuous), .start(start), .stop(stop),
    .hold_en(hold_en), .busy(busy), .done(done), .steps_left(steps_left),
    .bobinasMotor(bobinasMotor), .ledDirecc(ledDirecc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [3:0] SEQ [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                     4'b0010, 4'b0011, 4'b0001, 4'b1001};

  bit         m_run = 0;
  bit         m_dir = 0;
  bit         m_cont = 0;
  int         m_idx = 0;
  int         m_base = 0;
  int         m_stride = 2;
  int         m_per = 2;
  int         m_steps = 0;
  int         m_left = 0;
  int         m_elapsed = 0;
  logic [3:0] m_coils = 4'b0000;
  logic       m_done = 1'b0;
  logic       m_led = 1'b0;

  // Position is derived from elapsed cycles since acceptance: ticks = elapsed / period.
  always @(posedge clk) begin
    int ticks;
    int off;
    if (rst) begin
      m_run = 0; m_idx = 0; m_left = 0; m_done = 0; m_coils = 4'b0000; m_led = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && (continuous || steps != 0)) begin
          m_run     = 1;
          m_dir     = direcc;
          m_cont    = continuous;
          m_per     = (int'(period) < 2) ? 2 : int'(period);
          m_steps   = int'(steps);
          m_left    = continuous ? 0 : int'(steps);
          m_stride  = (mode == 2'b10) ? 1 : 2;
          if (mode == 2'b00)      m_base = m_idx - (m_idx % 2);
          else if (mode == 2'b10) m_base = m_idx;
          else                    m_base = m_idx - (m_idx % 2) + 1;
          m_idx     = m_base;
          m_elapsed = 0;
          m_led     = direcc;
          m_coils   = SEQ[m_idx];
        end else begin
          if (start) m_done = 1;
          m_coils = hold_en ? SEQ[m_idx] : 4'b0000;
        end
      end else begin
        m_elapsed++;
        ticks = m_elapsed / m_per;
        if (m_elapsed % m_per == 0) begin
          off   = (m_stride * ticks) % 8;
          m_idx = m_dir ? (m_base + off) % 8 : (m_base + 8 - off) % 8;
          if (!m_cont) m_left = m_steps - ticks;
        end
        m_coils = SEQ[m_idx];
        if ((!m_cont && ticks == m_steps) || stop) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  bit         chk_en = 0;
  bit         rec_en = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_coils = 4'b0000;
  int         busy_cnt = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_busy",  {31'd0, busy},       {31'd0, m_run});
      check("m_done",  {31'd0, done},       {31'd0, m_done});
      check("m_left",  {16'd0, steps_left}, m_left);
      check("m_coils", {28'd0, bobinasMotor}, {28'd0, m_coils});
      check("m_led",   {31'd0, ledDirecc},  {31'd0, m_led});
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (rec_en && bobinasMotor !== prev_coils) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL coil_seq: unexpected change to %b at %0t", bobinasMotor, $time);
        end else begin
          check("coil_seq", {28'd0, bobinasMotor}, {28'd0, exp_q.pop_front()});
        end
      end
    end
    prev_coils = bobinasMotor;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [1:0] md, input logic dr, input int per,
                          input int st, input logic ct);
    mode = md; direcc = dr; period = DIV_W'(per); steps = CNT_W'(st); continuous = ct;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick(1);
      i++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int b0, d0;

  initial begin
    rst = 1; start = 0; stop = 0; mode = 0; direcc = 0; period = '0;
    steps = '0; continuous = 0; hold_en = 1;
    tick(3);
    chk_en = 1;
    check("rst_coils", {28'd0, bobinasMotor}, 32'h0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_left",  {16'd0, steps_left}, 32'd0);
    check("rst_led",   {31'd0, ledDirecc}, 32'd0);
    rst = 0;
    tick(2);
    check("idle_hold_idx0", {28'd0, bobinasMotor}, 32'b1000);

    // Half, forward, 8 steps, period 4, from idx 0.
    exp_q = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
    b0 = busy_cnt; d0 = done_cnt;
    rec_en = 1;
    do_start(2'b10, 1'b1, 4, 8, 1'b0);
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    check("t1_led", {31'd0, ledDirecc}, 32'd1);
    wait_idle(100);
    tick(2);
    rec_en = 0;
    check("t1_seq_drained", exp_q.size(), 32'd0);
    check("t1_busy_cycles", busy_cnt - b0, 32'd32);
    check("t1_done_pulses", done_cnt - d0, 32'd1);
    check("t1_left", {16'd0, steps_left}, 32'd0);

    // Half, forward, 3 steps: park at idx 3.
    do_start(2'b10, 1'b1, 3, 3, 1'b0);
    wait_idle(100);
    tick(1);
    check("t2_coils_idx3", {28'd0, bobinasMotor}, 32'b0110);

    // Wave, reverse, 3 steps from idx 3: align to 2, then 0, 6, 4.
    exp_q = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    b0 = busy_cnt;
    rec_en = 1;
    do_start(2'b00, 1'b0, 2, 3, 1'b0);
    check("t3_aligned", {28'd0, bobinasMotor}, 32'b0100);
    check("t3_led", {31'd0, ledDirecc}, 32'd0);
    wait_idle(100);
    tick(2);
    rec_en = 0;
    check("t3_seq_drained", exp_q.size(), 32'd0);
    check("t3_busy_cycles", busy_cnt - b0, 32'd6);

    // Reset in the middle of a move.
    d0 = done_cnt;
    do_start(2'b10, 1'b1, 4, 10, 1'b0);
    tick(7);
    rst = 1;
    tick(1);
    check("t4_coils", {28'd0, bobinasMotor}, 32'h0);
    check("t4_busy",  {31'd0, busy}, 32'd0);
    check("t4_done",  {31'd0, done}, 32'd0);
    check("t4_left",  {16'd0, steps_left}, 32'd0);
    rst = 0;
    tick(2);
    check("t4_no_done", done_cnt - d0, 32'd0);

    // Double, continuous, period 1 clamped to 2, stop on a tick edge.
    exp_q = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110};
    d0 = done_cnt;
    rec_en = 1;
    do_start(2'b01, 1'b1, 1, 0, 1'b1);
    check("t5_first", {28'd0, bobinasMotor}, 32'b1100);
    tick(9);
    stop = 1;
    tick(1);
    stop = 0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_left", {16'd0, steps_left}, 32'd0);
    tick(2);
    rec_en = 0;
    check("t5_seq_drained", exp_q.size(), 32'd0);
    check("t5_done_pulses", done_cnt - d0, 32'd1);

    // Zero-length move.
    do_start(2'b10, 1'b1, 4, 0, 1'b0);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_coils", {28'd0, bobinasMotor}, 32'b0110);
    tick(1);
    check("t6_done_clear", {31'd0, done}, 32'd0);

    // Move ending at 0011 with a start ignored during RUN, then hold toggling.
    do_start(2'b10, 1'b1, 3, 2, 1'b0);
    tick(1);
    steps = CNT_W'(9);
    start = 1;
    tick(1);
    start = 0;
    check("t7_left_kept", {16'd0, steps_left}, 32'd2);
    check("t7_busy", {31'd0, busy}, 32'd1);
    wait_idle(100);
    tick(1);
    check("t7_end_coils", {28'd0, bobinasMotor}, 32'b0011);
    hold_en = 0;
    tick(1);
    check("t7_hold_off", {28'd0, bobinasMotor}, 32'b0000);
    hold_en = 1;
    tick(1);
    check("t7_hold_on", {28'd0, bobinasMotor}, 32'b0011);
    stop = 1;
    tick(1);
    stop = 0;
    check("t7_stop_idle", {31'd0, busy}, 32'd0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
